play_ctrl: RTL and testbench

- Top-level game sequencer for the note-playing game.
- Owns song selection, a 3-2-1 start countdown, play enable, pause entry, and the end-of-song screen.
- Drives the suspend menu block (reset, step and confirm pulses), then acts on the menu's exit/reStart/Continue/reSelect result.
- Muxes the six 6-bit digit codes going to the display driver.

---
 rtl/play_pkg.sv | 32 +++
 rtl/play_ctrl_btn_edge.sv | 30 +++
 rtl/play_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_play_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/play_pkg.sv
// play_pkg: shared states, display digit codes and segment packing
// for the note-playing game sequencer.
package play_pkg;

  typedef enum logic [2:0] {
    SELECT,
    COUNT,
    PLAY,
    PAUSE,
    DONE
  } state_e;

  localparam logic [5:0] SEG_BLANK = 6'b001010;
  localparam logic [5:0] SEG_S     = 6'b011101;
  localparam logic [5:0] SEG_E     = 6'b001111;
  localparam logic [5:0] SEG_L     = 6'b010110;
  localparam logic [5:0] SEG_N     = 6'b011000;
  localparam logic [5:0] SEG_D     = 6'b001110;

  // Seg1 lands in the top bits, Seg6 in the bottom bits.
  function automatic logic [35:0] pack_segs(
    input logic [5:0] s1,
    input logic [5:0] s2,
    input logic [5:0] s3,
    input logic [5:0] s4,
    input logic [5:0] s5,
    input logic [5:0] s6
  );
    return {s1, s2, s3, s4, s5, s6};
  endfunction

endpackage

// File: rtl/play_ctrl_btn_edge.sv
// btn_edge: 2-flop synchronizer plus rising-edge pulse.
// Ports: clk, rst (async high), din -> level (synced), rise (1-cycle pulse).
module btn_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/play_ctrl.sv
// play_ctrl: game sequencer - song select, 3-2-1 countdown, play,
// pause menu handshake, end screen, and display code mux.
// Ports: btn_* / song_done / menu_* in (async, synchronized here);
// menu_rst_n/prev/next/confirm, play_en, play_clr, song_id, segs out.
module play_ctrl #(
  parameter int NUM_SONGS     = 4,
  parameter int SONG_W        = 2,
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_prev,
  input  logic              btn_next,
  input  logic              btn_confirm,
  input  logic              btn_pause,
  input  logic              song_done,
  input  logic              menu_exit_n,
  input  logic              menu_restart,
  input  logic              menu_continue,
  input  logic              menu_reselect,
  input  logic [35:0]       menu_segs,
  input  logic [35:0]       play_segs,
  output logic              menu_rst_n,
  output logic              menu_prev,
  output logic              menu_next,
  output logic              menu_confirm,
  output logic              play_en,
  output logic              play_clr,
  output logic [SONG_W-1:0] song_id,
  output logic [35:0]       segs
);

  import play_pkg::*;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  logic [8:0] din, lvl, rise;

  assign din = {menu_reselect, menu_continue, menu_restart,
                menu_exit_n, song_done, btn_pause,
                btn_confirm, btn_next, btn_prev};

  // exit_n idles high, so its synchronizer resets high too.
  for (genvar i = 0; i < 9; i++) begin : g_sync
    btn_edge #(.RST_VAL(i == 5)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (din[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  logic prev_r, next_r, conf_r, pause_r;
  logic done_l, exit_n_l, restart_l, cont_l, resel_l;
  logic unused_ok;

  assign prev_r    = rise[0];
  assign next_r    = rise[1];
  assign conf_r    = rise[2];
  assign pause_r   = rise[3];
  assign done_l    = lvl[4];
  assign exit_n_l  = lvl[5];
  assign restart_l = lvl[6];
  assign cont_l    = lvl[7];
  assign resel_l   = lvl[8];
  assign unused_ok = ^{lvl[3:0], rise[8:4]};

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        digit_q, digit_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              clr_q, clr_d;
  logic              mprev_q, mprev_d;
  logic              mnext_q, mnext_d;
  logic              mconf_q, mconf_d;
  logic              mrstn_q, mrstn_d;
  logic [35:0]       segs_q, segs_d;

  localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    tick_d   = '0;
    digit_d  = 2'd3;
    settle_d = '0;
    clr_d    = 1'b0;
    mprev_d  = 1'b0;
    mnext_d  = 1'b0;
    mconf_d  = 1'b0;
    unique case (state_q)
      SELECT: begin
        if (next_r && !prev_r) begin
          song_d = (song_q == SONG_MAX) ? '0
                 : song_q + SONG_W'(1);
        end else if (prev_r && !next_r) begin
          song_d = (song_q == '0) ? SONG_MAX
                 : song_q - SONG_W'(1);
        end
        if (conf_r) begin
          state_d = COUNT;
          clr_d   = 1'b1;
        end
      end
      COUNT: begin
        digit_d = digit_q;
        tick_d  = tick_q + TW'(1);
        if (tick_q == TW'(TICK_CYCLES - 1)) begin
          tick_d = '0;
          if (digit_q == 2'd1) state_d = PLAY;
          else digit_d = digit_q - 2'd1;
        end
      end
      PLAY: begin
        if (done_l)       state_d = DONE;
        else if (pause_r) state_d = PAUSE;
      end
      PAUSE: begin
        if (settle_q == '0) begin
          mprev_d = prev_r;
          mnext_d = next_r;
          mconf_d = conf_r;
          // extra count covers the cycle the pulse itself is out
          if (conf_r) settle_d = SW'(SETTLE_CYCLES + 1);
        end else if (settle_q == SW'(1)) begin
          // reselect before continue: menu raises both on reselect
          if (!exit_n_l || resel_l) begin
            state_d = SELECT;
            clr_d   = 1'b1;
          end else if (restart_l) begin
            state_d = COUNT;
            clr_d   = 1'b1;
          end else if (cont_l) begin
            state_d = COUNT;
          end
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      DONE: begin
        if (conf_r) state_d = SELECT;
      end
      default: state_d = SELECT;
    endcase

    // low on the PAUSE entry cycle and everywhere outside PAUSE
    mrstn_d = (state_q == PAUSE) && (state_d == PAUSE);

    segs_d = play_segs;
    unique case (state_q)
      SELECT: segs_d = pack_segs(SEG_BLANK, SEG_S, SEG_E, SEG_L,
                                 SEG_BLANK, 6'(song_q) + 6'd1);
      COUNT:  segs_d = pack_segs(SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                 SEG_BLANK, SEG_BLANK, {4'd0, digit_q});
      PLAY:   segs_d = play_segs;
      PAUSE:  segs_d = menu_segs;
      DONE:   segs_d = pack_segs(SEG_BLANK, SEG_BLANK, SEG_E, SEG_N,
                                 SEG_D, SEG_BLANK);
      default: segs_d = play_segs;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SELECT;
      song_q   <= '0;
      tick_q   <= '0;
      digit_q  <= 2'd3;
      settle_q <= '0;
      clr_q    <= 1'b0;
      mprev_q  <= 1'b0;
      mnext_q  <= 1'b0;
      mconf_q  <= 1'b0;
      mrstn_q  <= 1'b0;
      segs_q   <= pack_segs(SEG_BLANK, SEG_S, SEG_E, SEG_L,
                            SEG_BLANK, 6'd1);
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      tick_q   <= tick_d;
      digit_q  <= digit_d;
      settle_q <= settle_d;
      clr_q    <= clr_d;
      mprev_q  <= mprev_d;
      mnext_q  <= mnext_d;
      mconf_q  <= mconf_d;
      mrstn_q  <= mrstn_d;
      segs_q   <= segs_d;
    end
  end

  assign play_en      = (state_q == PLAY);
  assign play_clr     = clr_q;
  assign menu_prev    = mprev_q;
  assign menu_next    = mnext_q;
  assign menu_confirm = mconf_q;
  assign menu_rst_n   = mrstn_q;
  assign song_id      = song_q;
  assign segs         = segs_q;

endmodule

// File: tb/tb_play_ctrl.sv
// tb_play_ctrl: directed self-checking bench for play_ctrl
// (song select, countdown, pause menu, end screen, async reset).
module tb_play_ctrl;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int TC = 4;
  localparam int SC = 3;

  localparam logic [5:0] C_BL = 6'b001010;
  localparam logic [5:0] C_S  = 6'b011101;
  localparam logic [5:0] C_E  = 6'b001111;
  localparam logic [5:0] C_L  = 6'b010110;
  localparam logic [5:0] C_N  = 6'b011000;
  localparam logic [5:0] C_D  = 6'b001110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_prev = 0, btn_next = 0, btn_confirm = 0, btn_pause = 0;
  logic song_done = 0;
  logic menu_exit_n = 1, menu_restart = 0;
  logic menu_continue = 0, menu_reselect = 0;
  logic [35:0] menu_segs = 36'hABCDE1234;
  logic [35:0] play_segs = 36'h123456789;
  logic menu_rst_n, menu_prev, menu_next, menu_confirm;
  logic play_en, play_clr;
  logic [SW-1:0] song_id;
  logic [35:0] segs;

  always #5 clk = ~clk;

  play_ctrl #(
    .NUM_SONGS(NS), .SONG_W(SW),
    .TICK_CYCLES(TC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_prev(btn_prev), .btn_next(btn_next),
    .btn_confirm(btn_confirm), .btn_pause(btn_pause),
    .song_done(song_done),
    .menu_exit_n(menu_exit_n), .menu_restart(menu_restart),
    .menu_continue(menu_continue), .menu_reselect(menu_reselect),
    .menu_segs(menu_segs), .play_segs(play_segs),
    .menu_rst_n(menu_rst_n), .menu_prev(menu_prev),
    .menu_next(menu_next), .menu_confirm(menu_confirm),
    .play_en(play_en), .play_clr(play_clr),
    .song_id(song_id), .segs(segs)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [35:0] sel_scr(input int d);
    return {C_BL, C_S, C_E, C_L, C_BL, 6'(d)};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 prev, 1 next, 2 confirm, 3 pause, 4 prev+next together
  task automatic press(input int b);
    case (b)
      0: btn_prev = 1;
      1: btn_next = 1;
      2: btn_confirm = 1;
      3: btn_pause = 1;
      default: begin btn_prev = 1; btn_next = 1; end
    endcase
    cyc(2);
    btn_prev = 0; btn_next = 0; btn_confirm = 0; btn_pause = 0;
  endtask

  int seq_b [7] = '{1, 1, 1, 1, 1, 0, 0};
  int exp_s [7] = '{1, 2, 3, 0, 1, 0, 3};
  int cnt;

  initial begin
    cyc(2);
    chk("rst_song", 36'(song_id), 36'(0));
    chk("rst_segs", segs, sel_scr(1));
    chk("rst_play_en", 36'(play_en), 36'(0));
    chk("rst_play_clr", 36'(play_clr), 36'(0));
    chk("rst_menu_rst_n", 36'(menu_rst_n), 36'(0));
    chk("rst_pulses", 36'({menu_prev, menu_next, menu_confirm}), 36'(0));
    rst = 0;
    cyc(1);

    for (int i = 0; i < 7; i++) begin
      press(seq_b[i]);
      cyc(4);
      chk("sel_song", 36'(song_id), 36'(exp_s[i]));
      chk("sel_digit", 36'(segs[5:0]), 36'(exp_s[i] + 1));
    end
    press(4);
    cyc(4);
    chk("sel_both", 36'(song_id), 36'(3));

    press(2);
    cyc(1);
    chk("cnt_clr", 36'(play_clr), 36'(1));
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk("cnt_digit", 36'(segs), 36'({C_BL, C_BL, C_BL, C_BL, C_BL,
                                       6'(3 - (i - 1) / 4)}));
      chk("cnt_play_en", 36'(play_en), 36'(i == 12));
      if (i == 1) chk("cnt_clr_once", 36'(play_clr), 36'(0));
    end
    cyc(1);
    chk("play_segs", segs, play_segs);

    chk("pre_pause_en", 36'(play_en), 36'(1));
    press(3);
    cyc(1);
    chk("pause_en", 36'(play_en), 36'(0));
    chk("pause_rst_lo", 36'(menu_rst_n), 36'(0));
    cyc(1);
    chk("pause_rst_hi", 36'(menu_rst_n), 36'(1));
    chk("pause_segs", segs, menu_segs);

    btn_next = 1;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 2) btn_next = 0;
      cnt += int'(menu_next);
    end
    chk("menu_next_cnt", 36'(cnt), 36'(1));

    menu_continue = 1;
    menu_reselect = 1;
    cyc(3);
    press(2);
    cyc(1);
    chk("menu_conf", 36'(menu_confirm), 36'(1));
    cyc(4);
    chk("resel_clr", 36'(play_clr), 36'(1));
    chk("resel_rst_n", 36'(menu_rst_n), 36'(0));
    cyc(1);
    chk("resel_segs", segs, sel_scr(4));

    press(2);
    cyc(14);
    chk("replay_en", 36'(play_en), 36'(1));
    press(3);
    cyc(2);
    chk("repause_en", 36'(play_en), 36'(0));
    menu_reselect = 0;
    cyc(2);
    press(2);
    cyc(1);
    chk("menu_conf2", 36'(menu_confirm), 36'(1));
    cyc(4);
    cnt = int'(play_clr);
    chk("cont_en_lo", 36'(play_en), 36'(0));
    repeat (11) begin
      cyc(1);
      cnt += int'(play_clr);
    end
    chk("cont_en_late", 36'(play_en), 36'(0));
    cyc(1);
    chk("cont_en_back", 36'(play_en), 36'(1));
    chk("cont_no_clr", 36'(cnt), 36'(0));

    song_done = 1;
    btn_pause = 1;
    cyc(2);
    btn_pause = 0;
    cyc(2);
    chk("done_segs", segs, {C_BL, C_BL, C_E, C_N, C_D, C_BL});
    chk("done_en", 36'(play_en), 36'(0));
    song_done = 0;
    press(2);
    cyc(2);
    chk("done_sel", segs, sel_scr(4));

    press(2);
    cyc(6);
    rst = 1;
    #1;
    chk("arst_song", 36'(song_id), 36'(0));
    chk("arst_segs", segs, sel_scr(1));
    chk("arst_en", 36'(play_en), 36'(0));
    chk("arst_clr", 36'(play_clr), 36'(0));
    chk("arst_rst_n", 36'(menu_rst_n), 36'(0));
    cyc(1);
    rst = 0;
    cyc(3);
    chk("post_rst_segs", segs, sel_scr(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
